// File: rtl/jtag_host_pkg.sv
// Shared types and constants for the JTAG host engine: op codes, FSM states
// and the TMS patterns walked from Run-Test/Idle.
package jtag_host_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_IR    = 2'd1,
    OP_DR    = 2'd2,
    OP_IDLE  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_HEAD,
    ST_SHIFT,
    ST_TAIL,
    ST_DONE
  } state_e;

  localparam int HEAD_DR   = 3;
  localparam int HEAD_IR   = 4;
  localparam int TAIL      = 2;
  localparam int RESET_LEN = 6;

  // Patterns are LSB-first: bit k is the TMS value on the k-th TCK.
  localparam logic [7:0] TMS_RESET   = 8'b0001_1111;
  localparam logic [7:0] TMS_HEAD_IR = 8'b0000_0011;
  localparam logic [7:0] TMS_HEAD_DR = 8'b0000_0001;
  localparam logic [1:0] TMS_TAIL    = 2'b01;

  function automatic logic [7:0] head_tms(op_e op);
    case (op)
      OP_RESET: return TMS_RESET;
      OP_IR:    return TMS_HEAD_IR;
      default:  return TMS_HEAD_DR;
    endcase
  endfunction

  function automatic logic [4:0] head_last(op_e op);
    case (op)
      OP_RESET: return 5'(RESET_LEN - 1);
      OP_IR:    return 5'(HEAD_IR - 1);
      default:  return 5'(HEAD_DR - 1);
    endcase
  endfunction

endpackage

// File: rtl/jtag_host_if.sv
// Command/response port of the JTAG host engine.
interface jtag_host_if;
  import jtag_host_pkg::*;

  // A command transfers on a clk edge where cmd_valid & cmd_ready are both 1;
  // the requester holds cmd_* steady until then. rsp_valid is a one-cycle
  // pulse with no back-pressure; rsp_data stays valid until the next response.
  logic        cmd_valid;
  logic        cmd_ready;
  op_e         cmd_op;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK generator: CLK_DIV low cycles then CLK_DIV high cycles while enabled,
// with strobes marking the clk edges where tck rises and falls.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          wrap;

  // Disabled means counter cleared and tck low, so enabling always starts a
  // fresh low phase.
  always_comb begin
    wrap     = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d    = '0;
    tck_d    = 1'b0;
    rise_stb = en && wrap && !tck_q;
    fall_stb = en && wrap && tck_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      tck_d = wrap ? ~tck_q : tck_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck = tck_q;

endmodule

// File: rtl/jtag_host_engine.sv
// Command-driven JTAG initiator: walks the TAP from Run-Test/Idle through
// reset, idle clocking or IR/DR shifts and returns the captured TDO bits.
module jtag_host_engine
  import jtag_host_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  jtag_host_if.slave cmd_if,
  output logic       tck,
  output logic       tms,
  output logic       tdi,
  input  logic       tdo,
  output state_e     dbg_state
);
  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [4:0]  len_q, len_d, bit_q, bit_d;
  logic [31:0] data_q, data_d, cap_q, cap_d, rsp_q, rsp_d;
  logic        boot_q, boot_d;
  logic        tck_en, fall_stb, rise_stb, last, ready;
  logic [7:0]  head_pat;
  logic [4:0]  head_end;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tck_en),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_d    = len_q;
    data_d   = data_q;
    bit_d    = bit_q;
    cap_d    = cap_q;
    rsp_d    = rsp_q;
    boot_d   = 1'b1;
    tck_en   = 1'b0;
    tms      = 1'b0;
    tdi      = 1'b0;
    last     = 1'b0;
    ready    = 1'b0;
    head_pat = head_tms(op_q);
    head_end = head_last(op_q);

    // boot_q holds INIT's first low phase off until the cycle after reset release.
    case (state_q)
      ST_INIT: begin
        tck_en = boot_q;
        tms    = TMS_RESET[bit_q[2:0]];
        last   = (bit_q == 5'(RESET_LEN - 1));
      end
      ST_HEAD: begin
        tck_en = 1'b1;
        tms    = head_pat[bit_q[2:0]];
        last   = (bit_q == head_end);
      end
      ST_SHIFT: begin
        tck_en = 1'b1;
        last   = (bit_q == len_q);
        tms    = (op_q != OP_IDLE) && last;
        tdi    = (op_q != OP_IDLE) && data_q[bit_q];
        if (rise_stb && op_q != OP_IDLE) cap_d[bit_q] = tdo;
      end
      ST_TAIL: begin
        tck_en = 1'b1;
        tms    = TMS_TAIL[bit_q[0]];
        last   = (bit_q == 5'(TAIL - 1));
      end
      default: ready = 1'b1;
    endcase

    // Phases advance on the falling TCK edge so tms/tdi settle in the low phase.
    if (fall_stb) begin
      bit_d = last ? 5'd0 : bit_q + 5'd1;
      if (last) begin
        case (state_q)
          ST_INIT:  state_d = ST_IDLE;
          ST_HEAD:  state_d = (op_q == OP_RESET) ? ST_DONE : ST_SHIFT;
          ST_SHIFT: state_d = (op_q == OP_IDLE) ? ST_DONE : ST_TAIL;
          ST_TAIL:  state_d = ST_DONE;
          default:  state_d = state_q;
        endcase
      end
    end

    if (state_q == ST_DONE) state_d = ST_IDLE;

    if (ready && cmd_if.cmd_valid) begin
      op_d    = cmd_if.cmd_op;
      len_d   = cmd_if.cmd_len;
      data_d  = cmd_if.cmd_data;
      bit_d   = 5'd0;
      cap_d   = '0;
      state_d = (cmd_if.cmd_op == OP_IDLE) ? ST_SHIFT : ST_HEAD;
    end

    if (state_d == ST_DONE) rsp_d = cap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      op_q    <= OP_RESET;
      len_q   <= '0;
      data_q  <= '0;
      bit_q   <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      boot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
      boot_q  <= boot_d;
    end
  end

  assign cmd_if.cmd_ready = ready;
  assign cmd_if.rsp_valid = (state_q == ST_DONE);
  assign cmd_if.rsp_data  = rsp_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_jtag_host_engine.sv
// Directed bench for jtag_host_engine with a TAP state model and a 1-bit
// bypass register on the far end of the chain.
module tb_jtag_host_engine;
  import jtag_host_pkg::*;

  localparam int CLK_DIV = 2;

  localparam int TLR = 0, RTI = 1, SEL_DR = 2, CAP_DR = 3, SH_DR = 4, EX1_DR = 5,
                 PAU_DR = 6, EX2_DR = 7, UPD_DR = 8, SEL_IR = 9, CAP_IR = 10,
                 SH_IR = 11, EX1_IR = 12, PAU_IR = 13, EX2_IR = 14, UPD_IR = 15;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   tck, tms, tdi, tdo;
  state_e dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;

  logic [0:0] exp_q[$];
  logic [0:0] tdi_exp_q[$];

  jtag_host_if bus ();

  jtag_host_engine #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_if    (bus),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- TAP model ----------------
  int   tap_st = TLR;
  logic byp_q = 1'b0;
  logic tdo_byp = 1'b0;
  logic tdo_one = 1'b0;

  assign tdo = tdo_one ? 1'b1 : tdo_byp;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:    return m ? TLR    : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PAU_DR;
      PAU_DR: return m ? EX2_DR : PAU_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR    : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PAU_IR;
      PAU_IR: return m ? EX2_IR : PAU_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      UPD_IR: return m ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck) begin
    if (tap_st == CAP_DR) byp_q <= 1'b0;
    else if (tap_st == SH_DR) byp_q <= tdi;
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck) tdo_byp <= byp_q;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every TCK rise must consume one expected TMS bit, and TDI must
  // match the queued data bit while the TAP shifts, else be 0.
  always @(posedge tck) begin
    logic [0:0] e;
    chk("tck_expected", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tms_seq", 64'(tms), 64'(e));
    end
    if ((tap_st == SH_DR || tap_st == SH_IR) && tdi_exp_q.size() > 0) begin
      e = tdi_exp_q.pop_front();
      chk("tdi_shift", 64'(tdi), 64'(e));
    end else begin
      chk("tdi_zero", 64'(tdi), 64'd0);
    end
  end

  logic tck_prev = 1'b0, tms_prev = 1'b0, tdi_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && tck && tck_prev)
      chk("tms_tdi_stable_high", {62'd0, tms, tdi}, {62'd0, tms_prev, tdi_prev});
    tck_prev <= tck;
    tms_prev <= tms;
    tdi_prev <= tdi;
  end

  always @(posedge clk) if (bus.rsp_valid === 1'b1) rsp_cnt++;

  // ---------------- driver tasks ----------------
  task automatic push_exp(input op_e op, input logic [4:0] len, input logic [31:0] data);
    case (op)
      OP_RESET: begin
        for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
      end
      OP_IDLE: for (int i = 0; i <= int'(len); i++) exp_q.push_back(1'b0);
      default: begin
        exp_q.push_back(1'b1);
        if (op == OP_IR) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        for (int i = 0; i <= int'(len); i++) begin
          exp_q.push_back(1'(i == int'(len)));
          tdi_exp_q.push_back(data[i]);
        end
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
      end
    endcase
  endtask

  task automatic release_reset(input string tag);
    push_exp(OP_RESET, 5'd0, 32'd0);
    rst_n = 1'b1;
    cyc = 0;
    while (bus.cmd_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_ready_cycle"}, 64'(cyc), 64'd25);
    chk({tag, "_tap_rti"}, 64'(tap_st), 64'(RTI));
    chk({tag, "_tms_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic start_cmd(input op_e op, input logic [4:0] len, input logic [31:0] data);
    chk("ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
    push_exp(op, len, data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = op_e'(2'($urandom_range(0, 3)));
    bus.cmd_len   = 5'($urandom_range(0, 31));
    bus.cmd_data  = $urandom;
    cyc = 1;
  endtask

  task automatic wait_rsp(input string tag, input int exp_cyc, input logic [31:0] exp_data);
    while (bus.rsp_valid !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_rsp_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_ready_with_rsp"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(exp_data));
    chk({tag, "_tap_rti"}, 64'(tap_st), 64'(RTI));
    chk({tag, "_tms_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_tdi_left"}, 64'(tdi_exp_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_RESET;
    bus.cmd_len   = 5'd0;
    bus.cmd_data  = 32'd0;
    repeat (3) @(negedge clk);

    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);

    release_reset("init");
    chk("init_no_rsp", 64'(rsp_cnt), 64'd0);

    // DR 8 bits through bypass: captured 0 then data delayed by one bit.
    tdo_one = 1'b0;
    start_cmd(OP_DR, 5'd7, 32'h0000_00A5);
    wait_rsp("dr8_bypass", 53, 32'h0000_004A);
    @(negedge clk);

    tdo_one = 1'b1;
    start_cmd(OP_IR, 5'd3, 32'h0000_000E);
    wait_rsp("ir4", 41, 32'h0000_000F);
    @(negedge clk);

    start_cmd(OP_RESET, 5'd17, 32'h1234_5678);
    wait_rsp("tap_reset", 25, 32'h0000_0000);
    @(negedge clk);

    tdo_one = 1'b0;
    start_cmd(OP_DR, 5'd0, 32'h0000_0001);
    wait_rsp("dr1_bypass", 25, 32'h0000_0000);
    @(negedge clk);

    tdo_one = 1'b1;
    start_cmd(OP_DR, 5'd31, 32'hDEAD_BEEF);
    wait_rsp("dr32_ones", 149, 32'hFFFF_FFFF);
    @(negedge clk);

    // Idle clocks followed by a DR accepted in the response cycle.
    tdo_one = 1'b0;
    start_cmd(OP_IDLE, 5'd9, 32'hFFFF_FFFF);
    wait_rsp("idle10", 41, 32'h0000_0000);
    start_cmd(OP_DR, 5'd3, 32'h0000_0009);
    wait_rsp("dr4_back2back", 37, 32'h0000_0002);

    repeat (5) @(negedge clk);
    chk("rsp_hold", 64'(bus.rsp_data), 64'h2);
    chk("rsp_pulse_count", 64'(rsp_cnt), 64'd7);

    // Reset in the middle of the SHIFT phase (second data bit, tck high).
    tdo_one = 1'b1;
    start_cmd(OP_DR, 5'd15, 32'h0000_FFFF);
    repeat (18) @(negedge clk);
    chk("mid_state_shift", 64'(dbg_state), 64'(ST_SHIFT));
    chk("mid_tck_high", 64'(tck), 64'd1);
    chk("mid_tdi_data", 64'(tdi), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tck", 64'(tck), 64'd0);
    chk("mid_rst_tms", 64'(tms), 64'd1);
    chk("mid_rst_tdi", 64'(tdi), 64'd0);
    chk("mid_rst_ready", 64'(bus.cmd_ready), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    exp_q.delete();
    tdi_exp_q.delete();
    repeat (3) @(negedge clk);
    release_reset("reinit");
    repeat (3) @(negedge clk);
    chk("mid_rst_no_rsp", 64'(rsp_cnt), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
